// File: rtl/cdb_wb_arbiter_if.sv
// Bundle of FU request and CDB broadcast signals for cdb_wb_arbiter.
// The master modport drives requests; the slave modport is the arbiter.
interface cdb_wb_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]            req_v_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic                          cdb_v_o;
    logic [DATA_WIDTH-1:0]         cdb_data_o;
    logic [SRC_W-1:0]              cdb_src_o;

    modport master (
        output req_v_i,
        output req_data_i,
        input  req_ready_o,
        input  cdb_v_o,
        input  cdb_data_o,
        input  cdb_src_o
    );

    modport slave (
        input  req_v_i,
        input  req_data_i,
        output req_ready_o,
        output cdb_v_o,
        output cdb_data_o,
        output cdb_src_o
    );
endinterface

// File: rtl/cdb_wb_arbiter.sv
// Round-robin CDB writeback arbiter with a one-entry holding slot per FU.
// Define CDB_ARB_FLUSH_EN to add the synchronous flush_i squash port.
module cdb_wb_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic             clk_i,
    input logic             reset_i,
`ifdef CDB_ARB_FLUSH_EN
    input logic             flush_i,
`endif
    cdb_wb_arbiter_if.slave wb_if
);
    localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    r_slot_v;
    logic [DATA_WIDTH-1:0] r_slot_data [NUM_REQ];
    logic [SRC_W-1:0]      r_rr_ptr;
    logic                  r_cdb_v;
    logic [DATA_WIDTH-1:0] r_cdb_data;
    logic [SRC_W-1:0]      r_cdb_src;

    logic [NUM_REQ-1:0]    w_grant;
    logic [NUM_REQ-1:0]    w_ready;
    logic [NUM_REQ-1:0]    w_accept;
    logic                  w_any_grant;
    logic [SRC_W-1:0]      w_win_idx;
    logic [SRC_W-1:0]      w_ptr_next;
    logic [DATA_WIDTH-1:0] w_win_data;
    logic                  w_flush;

`ifdef CDB_ARB_FLUSH_EN
    assign w_flush = flush_i;
`else
    assign w_flush = 1'b0;
`endif

    // Pass 0 scans slots at or above rr_ptr, pass 1 wraps to the ones below it.
    always_comb begin
        w_grant     = '0;
        w_any_grant = 1'b0;
        w_win_idx   = '0;
        w_win_data  = '0;
        for (int unsigned pass = 0; pass < 2; pass++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!w_any_grant && r_slot_v[i] &&
                    ((pass == 0) == (32'(r_rr_ptr) <= i))) begin
                    w_any_grant = 1'b1;
                    w_grant[i]  = 1'b1;
                    w_win_idx   = SRC_W'(i);
                    w_win_data  = r_slot_data[i];
                end
            end
        end
    end

    always_comb begin
        if (w_win_idx == SRC_W'(NUM_REQ - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_win_idx + SRC_W'(1);
        end
    end

    assign w_ready  = (~r_slot_v | w_grant) & ~{NUM_REQ{w_flush}};
    assign w_accept = wb_if.req_v_i & w_ready;

    // A granted slot accepting on the same edge reloads rather than clears.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_slot_v <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_slot_data[i] <= '0;
            end
        end else if (w_flush) begin
            r_slot_v <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (w_accept[i]) begin
                    r_slot_v[i]    <= 1'b1;
                    r_slot_data[i] <= wb_if.req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                end else if (w_grant[i]) begin
                    r_slot_v[i]    <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cdb_v    <= 1'b0;
            r_cdb_data <= '0;
            r_cdb_src  <= '0;
            r_rr_ptr   <= '0;
        end else if (w_flush) begin
            r_cdb_v    <= 1'b0;
            r_rr_ptr   <= '0;
        end else if (w_any_grant) begin
            r_cdb_v    <= 1'b1;
            r_cdb_data <= w_win_data;
            r_cdb_src  <= w_win_idx;
            r_rr_ptr   <= w_ptr_next;
        end else begin
            r_cdb_v    <= 1'b0;
        end
    end

    assign wb_if.req_ready_o = w_ready;
    assign wb_if.cdb_v_o     = r_cdb_v;
    assign wb_if.cdb_data_o  = r_cdb_data;
    assign wb_if.cdb_src_o   = r_cdb_src;

endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Table-driven bench for cdb_wb_arbiter (NUM_REQ=4, 8-bit payloads),
// plus hand sequences for async reset and, with CDB_ARB_FLUSH_EN, flush.
module tb_cdb_wb_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
`ifdef CDB_ARB_FLUSH_EN
    logic flush = 1'b0;
`endif

    always #5 clk = ~clk;

    cdb_wb_arbiter_if #(.NUM_REQ(NREQ), .DATA_WIDTH(DW)) bus ();

    cdb_wb_arbiter #(
        .NUM_REQ    (NREQ),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
`ifdef CDB_ARB_FLUSH_EN
        .flush_i (flush),
`endif
        .wb_if   (bus)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  rdy;
        logic        cv;
        logic [7:0]  cd;
        logic [1:0]  src;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic rst, input logic [3:0] v, input logic [31:0] d,
                       input logic [3:0] rdy, input logic cv, input logic [7:0] cd,
                       input logic [1:0] src);
        vec_t t;
        t.rst = rst; t.v = v; t.d = d; t.rdy = rdy; t.cv = cv; t.cd = cd; t.src = src;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [3:0] rdy, input logic cv,
                         input logic [7:0] cd, input logic [1:0] src);
        checks++;
        if (bus.req_ready_o !== rdy || bus.cdb_v_o !== cv ||
            bus.cdb_data_o !== cd || bus.cdb_src_o !== src) begin
            errors++;
            $display("FAIL %s: got rdy=%b v=%b data=%h src=%0d, want rdy=%b v=%b data=%h src=%0d",
                     name, bus.req_ready_o, bus.cdb_v_o, bus.cdb_data_o, bus.cdb_src_o,
                     rdy, cv, cd, src);
        end
    endtask

    task automatic pulse_reset();
        reset          = 1'b1;
        bus.req_v_i    = '0;
        bus.req_data_i = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input logic [3:0] v, input logic [31:0] d);
        bus.req_v_i    = v;
        bus.req_data_i = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req_v_i    = '0;
        bus.req_data_i = '0;

        // Reset then idle
        add(1, 4'b0000, 32'h0, 4'b1111, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) add(0, 4'b0000, 32'h0, 4'b1111, 0, 8'h00, 0);
        // Single FU2 request
        add(0, 4'b0100, 32'h00A50000, 4'b1111, 0, 8'h00, 0);
        add(0, 4'b0000, 32'h0,        4'b1111, 1, 8'hA5, 2);
        add(0, 4'b0000, 32'h0,        4'b1111, 0, 8'hA5, 2);
        // Round-robin, all four requesting, then drain
        add(1, 4'b1111, 32'h13121110, 4'b0001, 0, 8'h00, 0);
        add(0, 4'b1111, 32'h13121110, 4'b0010, 1, 8'h10, 0);
        add(0, 4'b1111, 32'h13121110, 4'b0100, 1, 8'h11, 1);
        add(0, 4'b1111, 32'h13121110, 4'b1000, 1, 8'h12, 2);
        add(0, 4'b1111, 32'h13121110, 4'b0001, 1, 8'h13, 3);
        add(0, 4'b1111, 32'h13121110, 4'b0010, 1, 8'h10, 0);
        add(0, 4'b0000, 32'h0,        4'b0110, 1, 8'h11, 1);
        add(0, 4'b0000, 32'h0,        4'b1110, 1, 8'h12, 2);
        add(0, 4'b0000, 32'h0,        4'b1111, 1, 8'h13, 3);
        add(0, 4'b0000, 32'h0,        4'b1111, 1, 8'h10, 0);
        add(0, 4'b0000, 32'h0,        4'b1111, 0, 8'h10, 0);
        // Back-to-back refill on FU1
        add(1, 4'b0010, 32'h00000100, 4'b1111, 0, 8'h00, 0);
        add(0, 4'b0010, 32'h00000200, 4'b1111, 1, 8'h01, 1);
        add(0, 4'b0010, 32'h00000300, 4'b1111, 1, 8'h02, 1);
        add(0, 4'b0000, 32'h0,        4'b1111, 1, 8'h03, 1);
        add(0, 4'b0000, 32'h0,        4'b1111, 0, 8'h03, 1);
        // FU0 and FU3 contending; unaccepted offers must not overwrite held data
        add(1, 4'b1001, 32'hB00000A0, 4'b0111, 0, 8'h00, 0);
        add(0, 4'b1001, 32'hB10000A1, 4'b1110, 1, 8'hA0, 0);
        add(0, 4'b1001, 32'hB20000A2, 4'b0111, 1, 8'hB0, 3);
        add(0, 4'b1001, 32'hB30000A3, 4'b1110, 1, 8'hA1, 0);
        add(0, 4'b0000, 32'h0,        4'b1111, 1, 8'hB2, 3);
        add(0, 4'b0000, 32'h0,        4'b1111, 1, 8'hA3, 0);
        add(0, 4'b0000, 32'h0,        4'b1111, 0, 8'hA3, 0);

        foreach (vecs[n]) begin
            if (vecs[n].rst) pulse_reset();
            step(vecs[n].v, vecs[n].d);
            check($sformatf("vec%0d", n), vecs[n].rdy, vecs[n].cv, vecs[n].cd, vecs[n].src);
        end

        // Asynchronous reset mid-operation drops pending slots with no replay
        pulse_reset();
        step(4'b1111, 32'h44332211);
        step(4'b0000, 32'h0);
        check("midop_pre", 4'b0011, 1, 8'h11, 0);
        #2;
        reset = 1'b1;
        #1;
        check("midop_async", 4'b1111, 0, 8'h00, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(4'b0000, 32'h0);
            check($sformatf("midop_after%0d", i), 4'b1111, 0, 8'h00, 0);
        end

`ifdef CDB_ARB_FLUSH_EN
        // Flush squashes filled slots; later traffic proceeds normally
        pulse_reset();
        step(4'b0111, 32'h00030201);
        check("flush_fill", 4'b1001, 0, 8'h00, 0);
        bus.req_v_i = 4'b0000;
        flush       = 1'b1;
        #1;
        check("flush_ready", 4'b0000, 0, 8'h00, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_edge", 4'b1111, 0, 8'h00, 0);
        for (int i = 0; i < 2; i++) begin
            step(4'b0000, 32'h0);
            check($sformatf("flush_idle%0d", i), 4'b1111, 0, 8'h00, 0);
        end
        step(4'b0100, 32'h00070000);
        check("flush_req", 4'b1111, 0, 8'h00, 0);
        step(4'b0000, 32'h0);
        check("flush_bcast", 4'b1111, 1, 8'h07, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
